// File: rtl/decomp_done_ctrl.sv
// decomp_done_ctrl: decides when a decompression page, and optionally each
// block within it, has fully drained through the token FIFO, the parsers and
// the history-RAM write queues.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               pulse, begins a page (honoured only in IDLE)
//   tf_empty            token FIFO empty
//   ps_empty[NP]        per-parser empty flags
//   ps_finish[NP]       per-parser block-end flags
//   ram_empty[NR]       per-bank write-queue empty flags
//   page_input_finish   pulse, last page input accepted
//   cl_finish           downstream acknowledge of page_finish
//   page_finish         level, page drained, held until cl_finish
//   block_finish        one-cycle pulse per drained block
//   busy                high whenever not IDLE
//   block_cnt[16]       blocks finished in the current page
//
// Configuration macro: DONE_CTRL_BLOCK_FINISH_EN enables block tracking
// (BLK_DRAIN state, block_finish, block_cnt). Undefined, ps_finish is ignored
// and block_finish/block_cnt are tied to 0.
module decomp_done_ctrl #(
  parameter int unsigned NUM_PARSER   = 6,
  parameter int unsigned NUM_RAM      = 16,
  parameter int unsigned DRAIN_CYCLES = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  tf_empty,
  input  logic [NUM_PARSER-1:0] ps_empty,
  input  logic [NUM_PARSER-1:0] ps_finish,
  input  logic [NUM_RAM-1:0]    ram_empty,
  input  logic                  page_input_finish,
  input  logic                  cl_finish,
  output logic                  page_finish,
  output logic                  block_finish,
  output logic                  busy,
  output logic [15:0]           block_cnt
);

  localparam int unsigned QCNT_W = 8;
  localparam int unsigned BCNT_W = 16;
  localparam logic [QCNT_W-1:0] DRAIN_MAX = QCNT_W'(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
`ifdef DONE_CTRL_BLOCK_FINISH_EN
    BLK_DRAIN = 3'd2,
`endif
    PG_DRAIN  = 3'd3,
    DONE      = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                all_empty_q, all_empty_d;
  logic [QCNT_W-1:0]   quiet_q, quiet_d;
  logic                pif_q, pif_d;
  logic                page_finish_q, page_finish_d;
  logic                busy_q, busy_d;
  logic                drained;

`ifdef DONE_CTRL_BLOCK_FINISH_EN
  logic                block_finish_q, block_finish_d;
  logic [BCNT_W-1:0]   block_cnt_q, block_cnt_d;
`else
  logic                unused_ps_finish;
  assign unused_ps_finish = ^ps_finish;
`endif

  // Quiet detection: count consecutive cycles with every source empty.
  always_comb begin
    all_empty_d = tf_empty & (&ps_empty) & (&ram_empty);
    if (!all_empty_q) begin
      quiet_d = '0;
    end else if (quiet_q >= DRAIN_MAX) begin
      quiet_d = DRAIN_MAX;
    end else begin
      quiet_d = QCNT_W'(quiet_q + QCNT_W'(1));
    end
  end

  assign drained = all_empty_q && (quiet_q == DRAIN_MAX);

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    pif_d         = pif_q;
    page_finish_d = 1'b0;
`ifdef DONE_CTRL_BLOCK_FINISH_EN
    block_finish_d = 1'b0;
    block_cnt_d    = block_cnt_q;
`endif

    if (state_q != IDLE && page_input_finish) begin
      pif_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
`ifdef DONE_CTRL_BLOCK_FINISH_EN
          block_cnt_d = '0;
`endif
        end
      end
      RUN: begin
        // A page end outranks a simultaneous block end.
        if (pif_q || page_input_finish) begin
          state_d = PG_DRAIN;
`ifdef DONE_CTRL_BLOCK_FINISH_EN
        end else if (|ps_finish) begin
          state_d = BLK_DRAIN;
`endif
        end
      end
`ifdef DONE_CTRL_BLOCK_FINISH_EN
      BLK_DRAIN: begin
        if (drained) begin
          state_d        = RUN;
          block_finish_d = 1'b1;
          block_cnt_d    = BCNT_W'(block_cnt_q + BCNT_W'(1));
        end
      end
`endif
      PG_DRAIN: begin
        if (drained) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // page_finish follows DONE one cycle later and drops with the ack.
        if (cl_finish) begin
          state_d = IDLE;
        end else begin
          page_finish_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      pif_d = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      all_empty_q   <= 1'b0;
      quiet_q       <= '0;
      pif_q         <= 1'b0;
      page_finish_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      all_empty_q   <= all_empty_d;
      quiet_q       <= quiet_d;
      pif_q         <= pif_d;
      page_finish_q <= page_finish_d;
      busy_q        <= busy_d;
    end
  end

`ifdef DONE_CTRL_BLOCK_FINISH_EN
  // Block tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_finish_q <= 1'b0;
      block_cnt_q    <= '0;
    end else begin
      block_finish_q <= block_finish_d;
      block_cnt_q    <= block_cnt_d;
    end
  end

  assign block_finish = block_finish_q;
  assign block_cnt    = block_cnt_q;
`else
  assign block_finish = 1'b0;
  assign block_cnt    = '0;
`endif

  assign page_finish = page_finish_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_decomp_done_ctrl.sv
// Scoreboard bench for decomp_done_ctrl (DRAIN_CYCLES=6, 6 parsers, 16 banks).
module tb_decomp_done_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        tf_empty;
  logic [5:0]  ps_empty;
  logic [5:0]  ps_finish;
  logic [15:0] ram_empty;
  logic        page_input_finish;
  logic        cl_finish;
  logic        page_finish;
  logic        block_finish;
  logic        busy;
  logic [15:0] block_cnt;

  decomp_done_ctrl #(
    .NUM_PARSER  (6),
    .NUM_RAM     (16),
    .DRAIN_CYCLES(6)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .tf_empty         (tf_empty),
    .ps_empty         (ps_empty),
    .ps_finish        (ps_finish),
    .ram_empty        (ram_empty),
    .page_input_finish(page_input_finish),
    .cl_finish        (cl_finish),
    .page_finish      (page_finish),
    .block_finish     (block_finish),
    .busy             (busy),
    .block_cnt        (block_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_page;
    int cyc;
    int cnt;
  } ev_t;

  ev_t  exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic pf_prev = 1'b0;

`ifdef DONE_CTRL_BLOCK_FINISH_EN
  localparam bit BLK_EN = 1'b1;
`else
  localparam bit BLK_EN = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input bit is_page, input int c, input int cnt);
    ev_t e;
    e.is_page = is_page;
    e.cyc     = c;
    e.cnt     = cnt;
    exp_q.push_back(e);
  endtask

  task automatic pop_ev(input bit is_page);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: actual=%s required=none (cyc %0d)",
               is_page ? "page_finish" : "block_finish", cyc);
    end else begin
      e = exp_q.pop_front();
      chk(is_page ? "ev_kind_page" : "ev_kind_block", 32'(is_page), 32'(e.is_page));
      chk(is_page ? "page_finish_cycle" : "block_finish_cycle", cyc, e.cyc);
      if (!is_page) chk("block_cnt_at_pulse", 32'(block_cnt), e.cnt);
    end
  endtask

  // Monitor: every page_finish rise and every block_finish cycle is an event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (page_finish && !pf_prev) pop_ev(1'b1);
      if (block_finish) pop_ev(1'b0);
    end
    pf_prev <= page_finish;
  end

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_src(input bit e);
    tf_empty  = e;
    ps_empty  = e ? 6'h3F : 6'h00;
    ram_empty = e ? 16'hFFFF : 16'h0000;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc_n(1);
    start = 1'b0;
  endtask

  task automatic pulse_pif();
    page_input_finish = 1'b1;
    cyc_n(1);
    page_input_finish = 1'b0;
  endtask

  task automatic pulse_cl();
    cl_finish = 1'b1;
    cyc_n(1);
    cl_finish = 1'b0;
  endtask

  task automatic wait_pf(input int lim);
    int n = 0;
    while (page_finish !== 1'b1 && n < lim) begin
      cyc_n(1);
      n++;
    end
    chk("page_finish_timeout", 32'(page_finish), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b0;
    start = 1'b0;
    ps_finish = '0;
    page_input_finish = 1'b0;
    cl_finish = 1'b0;
    set_src(1'b0);
    cyc_n(3);
    chk("rst_page_finish", 32'(page_finish), 0);
    chk("rst_block_finish", 32'(block_finish), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_block_cnt", 32'(block_cnt), 0);
    rst_n = 1'b1;
    cyc_n(2);

    // Basic page: empty after page end -> page_finish 8 cycles later.
    pulse_start();
    chk("busy_after_start", 32'(busy), 1);
    pulse_pif();
    set_src(1'b1);
    c0 = cyc + 1;
    push_ev(1'b1, c0 + 8, 0);
    cyc_n(1);
    wait_pf(20);
    cyc_n(2);
    chk("page_finish_held", 32'(page_finish), 1);
    pulse_cl();
    chk("page_finish_after_ack", 32'(page_finish), 0);
    chk("busy_after_ack", 32'(busy), 0);

    // One-cycle RAM bank activity at count 4 restarts the drain.
    set_src(1'b0);
    pulse_start();
    pulse_pif();
    set_src(1'b1);
    c0 = cyc + 1;
    cyc_n(5);
    ram_empty = 16'hFFFE;
    cyc_n(1);
    ram_empty = 16'hFFFF;
    push_ev(1'b1, c0 + 6 + 8, 0);
    wait_pf(30);
    pulse_cl();
    chk("busy_after_ack2", 32'(busy), 0);

    // Block end, then an immediate second block with sources already quiet.
    set_src(1'b0);
    pulse_start();
    ps_finish = 6'b000100;
    cyc_n(1);
    ps_finish = '0;
    set_src(1'b1);
    c0 = cyc + 1;
    if (BLK_EN) push_ev(1'b0, c0 + 7, 1);
    cyc_n(12);
    chk("blk_busy_run", 32'(busy), 1);
    chk("blk_no_page_finish", 32'(page_finish), 0);
    chk("blk_cnt_one", 32'(block_cnt), BLK_EN ? 1 : 0);
    ps_finish = 6'b100000;
    if (BLK_EN) push_ev(1'b0, cyc + 2, 2);
    cyc_n(1);
    ps_finish = '0;
    cyc_n(4);
    chk("blk_cnt_two", 32'(block_cnt), BLK_EN ? 2 : 0);

    // Simultaneous page end and block end: page wins.
    set_src(1'b0);
    cyc_n(2);
    page_input_finish = 1'b1;
    ps_finish = 6'b000001;
    cyc_n(1);
    page_input_finish = 1'b0;
    ps_finish = '0;
    set_src(1'b1);
    c0 = cyc + 1;
    push_ev(1'b1, c0 + 8, 0);
    cyc_n(1);
    wait_pf(20);
    chk("blk_cnt_unchanged", 32'(block_cnt), BLK_EN ? 2 : 0);
    pulse_cl();

    // Reset at drain count 3 abandons the page.
    set_src(1'b0);
    pulse_start();
    chk("blk_cnt_cleared_on_start", 32'(block_cnt), 0);
    pulse_pif();
    set_src(1'b1);
    cyc_n(4);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_page_finish", 32'(page_finish), 0);
    chk("midrst_block_finish", 32'(block_finish), 0);
    chk("midrst_block_cnt", 32'(block_cnt), 0);
    cyc_n(1);
    rst_n = 1'b1;
    cyc_n(20);
    chk("post_rst_no_finish", 32'(page_finish), 0);
    chk("post_rst_idle", 32'(busy), 0);

    // cl_finish in RUN and start in DONE are ignored.
    set_src(1'b0);
    pulse_start();
    pulse_cl();
    chk("cl_in_run_ignored", 32'(busy), 1);
    pulse_pif();
    cyc_n(2);
    chk("no_early_page_finish", 32'(page_finish), 0);
    set_src(1'b1);
    c0 = cyc + 1;
    push_ev(1'b1, c0 + 8, 0);
    cyc_n(1);
    wait_pf(20);
    pulse_start();
    cyc_n(3);
    chk("start_in_done_ignored", 32'(page_finish), 1);
    chk("busy_in_done", 32'(busy), 1);
    pulse_cl();
    chk("final_ack_page_finish", 32'(page_finish), 0);
    chk("final_ack_busy", 32'(busy), 0);

    cyc_n(5);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decomp_done_ctrl.md
DECOMP_DONE_CTRL -- requirements
Module: decomp_done_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_PARSER, default 6, number of parser channels.
REQ-002 The block SHALL have parameter NUM_RAM, default 16, number of history-RAM banks.
REQ-003 The block SHALL have parameter DRAIN_CYCLES, default 6, range 1..255, the required consecutive all-empty cycles before a finish.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1, single-cycle pulse that begins a page.
REQ-007 The block SHALL have port tf_empty, input, 1, token FIFO empty.
REQ-008 The block SHALL have port ps_empty, input, NUM_PARSER, per-parser empty flags.
REQ-009 The block SHALL have port ps_finish, input, NUM_PARSER, per-parser block-end flags.
REQ-010 The block SHALL have port ram_empty, input, NUM_RAM, per-bank write-queue empty flags.
REQ-011 The block SHALL have port page_input_finish, input, 1, pulse marking the last page input accepted.
REQ-012 The block SHALL have port cl_finish, input, 1, downstream acknowledge of page_finish.
REQ-013 The block SHALL have port page_finish, output, 1, level: page fully drained, held until acknowledged.
REQ-014 The block SHALL have port block_finish, output, 1, one-cycle pulse per drained block.
REQ-015 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 The block SHALL have port block_cnt, output, 16, blocks finished in current page.

Function
REQ-017 all_empty_r SHALL be registered each cycle as tf_empty AND all ps_empty bits AND all ram_empty bits.
REQ-018 quiet_cnt (8 bit) SHALL clear when all_empty_r is 0, else increment, saturating at DRAIN_CYCLES.
REQ-019 drained SHALL be defined as all_empty_r=1 AND quiet_cnt==DRAIN_CYCLES.
REQ-020 pif_flag SHALL set on page_input_finish in any non-IDLE state and clear on entry to IDLE; a page_input_finish in IDLE SHALL be ignored.
REQ-021 State IDLE: start=1 -> RUN; block_cnt cleared to 0 on this transition.
REQ-022 State RUN: (pif_flag OR page_input_finish)=1 -> PG_DRAIN; else any ps_finish bit=1 -> BLK_DRAIN; page event has priority when simultaneous.
REQ-023 State BLK_DRAIN: drained -> RUN with block_finish=1 for exactly that one cycle and block_cnt incremented (wraps at 16'hFFFF -> 0); page_input_finish while here is latched by pif_flag only.
REQ-024 State PG_DRAIN: drained -> DONE; page_finish SHALL rise exactly DRAIN_CYCLES+2 cycles after the first edge that samples all sources empty with pif_flag set.
REQ-025 State DONE: page_finish=1 held; cl_finish=1 -> IDLE, page_finish=0 from the next cycle.
REQ-026 cl_finish in any state other than DONE SHALL be ignored.
REQ-027 start in any state other than IDLE SHALL be ignored.
REQ-028 Any source going non-empty during BLK_DRAIN or PG_DRAIN SHALL restart the DRAIN_CYCLES count without leaving the state.
REQ-029 All outputs SHALL be registered; no combinational input-to-output path.
REQ-030 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state=IDLE, page_finish=0, block_finish=0, busy=0, block_cnt=0, pif_flag=0, quiet_cnt=0, all_empty_r=0.
REQ-032 Reset asserted mid-drain SHALL abandon the page; no finish output SHALL be issued after release until a new start.

Configuration
REQ-033 Macro DONE_CTRL_BLOCK_FINISH_EN defined: BLK_DRAIN, block_finish and block_cnt SHALL behave per REQ-022/023.
REQ-034 Macro DONE_CTRL_BLOCK_FINISH_EN undefined: BLK_DRAIN SHALL not exist, ps_finish SHALL be ignored, block_finish and block_cnt SHALL be constant 0; page behaviour unchanged.

Verification (DRAIN_CYCLES=6, NUM_PARSER=6, NUM_RAM=16, macro defined)
REQ-035 Reset release, start, all sources empty, page_input_finish pulse -> page_finish rises 8 cycles after first sampled all-empty, held until cl_finish, low on the following cycle, busy low.
REQ-036 In PG_DRAIN, ram_empty=16'hFFFE for 1 cycle at drain count 4 -> page_finish delayed by the full 8 cycles measured from re-empty.
REQ-037 ps_finish=6'b000100 in RUN, sources empty -> block_finish single-cycle pulse after drain, block_cnt=1, state RUN, page_finish stays 0.
REQ-038 page_input_finish and ps_finish=6'b000001 in the same RUN cycle -> PG_DRAIN taken, no block_finish, block_cnt unchanged.
REQ-039 rst_n low for 1 cycle at drain count 3 in PG_DRAIN -> all outputs 0 immediately, no page_finish after release without start.
REQ-040 cl_finish pulsed in RUN, start pulsed in DONE -> both ignored; DONE exit only on later cl_finish.
